// File: rtl/rom_burst_arb_if.sv
// rom_burst_arb_if: requester, ROM and read-return signals of the ROM burst arbiter
interface rom_burst_arb_if #(
  parameter int NREQ = 4,
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0] gnt;
  logic rom_ce;
  logic rom_ren;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic rd_valid;
  logic [DW-1:0] rd_data;
  logic [IDW-1:0] rd_id;
  logic rd_last;
  modport slave (
    input req, req_addr, req_len, rom_data,
    output gnt, rom_ce, rom_ren, rom_addr, rd_valid, rd_data, rd_id, rd_last
  );
  modport master (
    output req, req_addr, req_len, rom_data,
    input gnt, rom_ce, rom_ren, rom_addr, rd_valid, rd_data, rd_id, rd_last
  );
endinterface

// File: rtl/rom_burst_arb.sv
// rom_burst_arb: round-robin burst arbiter sharing one synchronous ROM among NREQ requesters
// Define ROM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module rom_burst_arb #(
  parameter int NREQ = 4,
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8,
  parameter int RD_LAT = 1,
  parameter int IDW = 2
) (
  input logic clk,
  input logic reset,
  rom_burst_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nxt;
  logic [NREQ-1:0] gnt, gnt_nxt;
  logic rom_ce, ce_nxt;
  logic [AW-1:0] rom_addr, addr_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [2:0] dcnt, dcnt_nxt;
  logic [IDW-1:0] cur_id, id_nxt, win;
  logic pv [RD_LAT];
  logic pl [RD_LAT];
  logic [IDW-1:0] pid [RD_LAT];
`ifndef ROM_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] ptr, ptr_nxt;
  function automatic int rr_idx(input logic [IDW-1:0] p, input int k);
    return (int'(p) + k >= NREQ) ? int'(p) + k - NREQ : int'(p) + k;
  endfunction
`endif
  always_comb begin
    win = '0;
`ifdef ROM_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) if (bus.req[k]) win = IDW'(k);
`else
    for (int k = NREQ - 1; k >= 0; k--) if (bus.req[rr_idx(ptr, k)]) win = IDW'(rr_idx(ptr, k));
    ptr_nxt = ptr;
`endif
    state_nxt = state;
    gnt_nxt = gnt;
    ce_nxt = rom_ce;
    addr_nxt = rom_addr;
    cnt_nxt = cnt;
    dcnt_nxt = dcnt;
    id_nxt = cur_id;
    case (state)
      IDLE: if (|bus.req) begin
        state_nxt = READ;
        gnt_nxt = NREQ'(1) << win;
        ce_nxt = 1'b1;
        addr_nxt = bus.req_addr[int'(win)*AW +: AW];
        cnt_nxt = bus.req_len[int'(win)*LW +: LW];
        id_nxt = win;
`ifndef ROM_ARB_FIXED_PRIO_EN
        ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`endif
      end
      READ: if (cnt == '0) begin
        state_nxt = DRAIN;
        ce_nxt = 1'b0;
        dcnt_nxt = 3'(RD_LAT - 1);
      end else begin
        addr_nxt = rom_addr + 1'b1;
        cnt_nxt = cnt - 1'b1;
      end
      DRAIN: if (dcnt == '0) begin
        state_nxt = IDLE;
        gnt_nxt = '0;
      end else begin
        dcnt_nxt = dcnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // return pipeline tracks each issued beat so rd_* line up with rom_data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      rom_ce <= 1'b0;
      rom_addr <= '0;
      cnt <= '0;
      dcnt <= '0;
      cur_id <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      ptr <= '0;
`endif
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pl[i] <= 1'b0;
        pid[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      gnt <= gnt_nxt;
      rom_ce <= ce_nxt;
      rom_addr <= addr_nxt;
      cnt <= cnt_nxt;
      dcnt <= dcnt_nxt;
      cur_id <= id_nxt;
`ifndef ROM_ARB_FIXED_PRIO_EN
      ptr <= ptr_nxt;
`endif
      pv[0] <= rom_ce;
      pl[0] <= rom_ce && cnt == '0;
      pid[0] <= cur_id;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end
  assign bus.gnt = gnt;
  assign bus.rom_ce = rom_ce;
  assign bus.rom_ren = rom_ce;
  assign bus.rom_addr = rom_addr;
  assign bus.rd_valid = pv[RD_LAT-1];
  assign bus.rd_last = pl[RD_LAT-1];
  assign bus.rd_id = pid[RD_LAT-1];
  assign bus.rd_data = bus.rom_data[DW-1:0];
endmodule

// File: tb/tb_rom_burst_arb.sv
// tb_rom_burst_arb: scoreboard bench for rom_burst_arb with a ~addr ROM model, RD_LAT=1
module tb_rom_burst_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rom_q = 8'h00;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic last;
  } exp_t;
  exp_t q[$];

  rom_burst_arb_if #(.NREQ(4), .AW(8), .DW(8), .LW(8), .IDW(2)) bus ();
  rom_burst_arb #(.NREQ(4), .AW(8), .DW(8), .LW(8), .RD_LAT(1), .IDW(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (bus.rom_ce && bus.rom_ren) rom_q <= ~bus.rom_addr;
  assign bus.rom_data = rom_q;

  always @(negedge clk) begin
    if (bus.rd_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: got id=%0d data=%h last=%b, required no beat", bus.rd_id, bus.rd_data, bus.rd_last);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.rd_id !== e.id || bus.rd_data !== e.data || bus.rd_last !== e.last) begin
          errors++;
          $display("FAIL rd_beat: got id=%0d data=%h last=%b, required id=%0d data=%h last=%b",
                   bus.rd_id, bus.rd_data, bus.rd_last, e.id, e.data, e.last);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic burst(input int id, input logic [7:0] a, input int len);
    logic [7:0] ad;
    step();
    bus.req[id] = 1'b1;
    bus.req_addr[id*8 +: 8] = a;
    bus.req_len[id*8 +: 8] = 8'(len);
    for (int i = 0; i <= len; i++) begin
      ad = a + 8'(i);
      q.push_back('{id: 2'(id), data: ~ad, last: (i == len)});
    end
    for (int i = 0; i <= len; i++) begin
      step();
      if (i == 0) begin
        bus.req[id] = 1'b0;
        bus.req_addr[id*8 +: 8] = 8'h99;
        bus.req_len[id*8 +: 8] = 8'h00;
      end
      chk("rom_addr", 32'(bus.rom_addr), 32'(8'(a + 8'(i))));
      chk("gnt_burst", 32'(bus.gnt), 32'(4'b1 << id));
      chk("rom_ce_ren", 32'({bus.rom_ce, bus.rom_ren}), 32'h3);
    end
    step();
    chk("gnt_drain", 32'(bus.gnt), 32'(4'b1 << id));
    chk("rom_ce_drain", 32'(bus.rom_ce), 32'h0);
    step();
    chk("gnt_drop", 32'(bus.gnt), 32'h0);
    chk("burst_drained", 32'(q.size()), 32'h0);
  endtask

  initial begin
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_len = '0;
    repeat (2) step();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rom_ce", 32'({bus.rom_ce, bus.rom_ren}), 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("rst_rd", 32'({bus.rd_valid, bus.rd_last, bus.rd_id}), 32'h0);
    reset = 1'b0;
    step();
    // contention: all four requesters held, single-beat bursts
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i*8 +: 8] = 8'h20 + 8'(i);
      bus.req_len[i*8 +: 8] = 8'h00;
    end
    bus.req = 4'hF;
`ifdef ROM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) q.push_back('{id: 2'd0, data: 8'hDF, last: 1'b1});
`else
    q.push_back('{id: 2'd0, data: 8'hDF, last: 1'b1});
    q.push_back('{id: 2'd1, data: 8'hDE, last: 1'b1});
    q.push_back('{id: 2'd2, data: 8'hDD, last: 1'b1});
    q.push_back('{id: 2'd3, data: 8'hDC, last: 1'b1});
    q.push_back('{id: 2'd0, data: 8'hDF, last: 1'b1});
`endif
    for (int t = 0; t < 100 && q.size() != 0; t++) step();
    bus.req = '0;
    chk("contention_drained", 32'(q.size()), 32'h0);
    for (int t = 0; t < 20 && bus.gnt != 0; t++) step();
    repeat (4) step();
    chk("contention_idle_gnt", 32'(bus.gnt), 32'h0);
    // single burst, wrap, max length
    burst(0, 8'h10, 3);
    burst(1, 8'hFE, 3);
    burst(3, 8'h00, 255);
    // reset during beat 2 of an 8-beat burst
    step();
    bus.req[1] = 1'b1;
    bus.req_addr[15:8] = 8'h30;
    bus.req_len[15:8] = 8'd7;
    q.push_back('{id: 2'd1, data: 8'hCF, last: 1'b0});
    q.push_back('{id: 2'd1, data: 8'hCE, last: 1'b0});
    step();
    bus.req[1] = 1'b0;
    step();
    step();
    chk("pre_reset_addr", 32'(bus.rom_addr), 32'h32);
    reset = 1'b1;
    #1;
    chk("mid_reset_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_reset_ce", 32'(bus.rom_ce), 32'h0);
    chk("mid_reset_valid", 32'(bus.rd_valid), 32'h0);
    chk("mid_reset_q", 32'(q.size()), 32'h0);
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    q.push_back('{id: 2'd2, data: 8'hBF, last: 1'b1});
    q.pop_back();
    burst(2, 8'h40, 0);
    chk("final_q_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule

// File: doc/rom_burst_arb.md
Name: rom_burst_arb

Overview:
- Arbitrates one single-port synchronous ROM (ce/ren/addr in, registered data out) between NREQ requesters.
- Each requester asks for a burst: a start address and a beat count. The block grants one requester at a time, round-robin, and sequences the ROM reads.
- Returns tagged read data with a last-beat flag.
- Sits between ROM-consuming engines (table walkers, microcode fetch) and the ROM instance.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 8, ROM address width
DW, 8, ROM data width
LW, 8, burst length field width; a value L means L+1 beats
RD_LAT, 1, ROM read latency in cycles from ce&ren to valid data (1..4)
IDW, 2, requester ID width, clog2(NREQ)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester burst request, level; held until gnt
req_addr  in  NREQ*AW  packed start addresses, requester i at [i*AW +: AW]
req_len  in  NREQ*LW  packed lengths (beats-1)
gnt  out  NREQ  one-hot grant, held for the whole burst including drain
rom_ce  out  1  ROM chip enable
rom_ren  out  1  ROM read enable
rom_addr  out  AW  ROM address
rom_data  in  DW  ROM read data
rd_valid  out  1  rd_data valid this cycle
rd_data  out  DW  returned data, equal to rom_data
rd_id  out  IDW  index of the granted requester
rd_last  out  1  final beat of the burst

Behaviour:
- Reset (async, active-high):
  - state=IDLE; gnt=0; rom_ce=rom_ren=0; rom_addr=0.
  - rd_valid=rd_last=0; rd_id=0.
  - RR pointer=0, so requester 0 has highest priority.
- Outputs gnt, rom_ce, rom_ren, rom_addr, rd_valid, rd_id, rd_last come from flops. rd_data is the rom_data input passed through.
- States: IDLE, READ, DRAIN.
- IDLE:
  - If req!=0, pick the first set bit searching from the RR pointer upward, wrapping modulo NREQ.
  - Latch the winner's addr/len into the address and beat counters; set gnt[winner]; go to READ.
  - The RR pointer becomes winner+1 mod NREQ.
  - If req==0, stay in IDLE.
- READ:
  - rom_ce=rom_ren=1 every cycle. rom_addr = start, start+1, ..., incrementing each cycle.
  - Address wraps modulo 2^AW: 0xFF is followed by 0x00.
  - Beat counter decrements each cycle. After the cycle issuing the final address, go to DRAIN.
  - rom_ce and rom_ren drop in that same transition.
- DRAIN: lasts RD_LAT cycles, then gnt<=0 and state returns to IDLE.
- Read return:
  - An RD_LAT-deep shift register of {valid, last, id} is loaded at each issue.
  - rd_valid, rd_id, rd_last align exactly with rom_data, RD_LAT cycles after the matching rom_ce cycle.
  - rd_last is asserted only with the final beat.
- Timing:
  - Burst of L+1 beats occupies 1 (IDLE) + L+1 (READ) + RD_LAT (DRAIN) cycles.
  - Minimum one IDLE cycle between bursts.
  - gnt rises with the first rom_ce.
- req is sampled only in IDLE:
  - Dropping req mid-burst has no effect; the burst completes.
  - req/addr/len changes during a burst are ignored.
- Simultaneous requests: RR order guarantees each active requester is granted within NREQ bursts.
- Length 0 gives a 1-beat burst; length 2^LW-1 gives 2^LW beats.
- Reset mid-burst: everything clears immediately, in-flight return beats are discarded, gnt drops, and no rd_valid follows.

Optional Feature:
- Macro: ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index set req always wins and the RR pointer logic is removed.
- Undefined: round-robin as above.
- All other timing is identical in both modes.

Test Plan:
- Bench ROM model: mem[a]=~a, RD_LAT=1.
- Single burst: req[0]=1, addr 0x10, len 3 -> gnt=0001; rom_addr 0x10..0x13 on 4 consecutive cycles; rd_data 0xEF,0xEE,0xED,0xEC with rd_id=0; rd_last only on 0xEC; gnt drops the cycle after that beat.
- Contention: req=1111 held, each len 0 -> grants in order 0,1,2,3,0; with ROM_ARB_FIXED_PRIO_EN defined -> requester 0 every time.
- Wrap: addr 0xFE, len 3 -> rom_addr 0xFE,0xFF,0x00,0x01; data 0x01,0x00,0xFF,0xFE.
- Max burst: len 0xFF from 0x00 -> 256 beats, exactly one rd_last, on addr 0xFF data 0x00.
- Reset mid-burst: assert reset on beat 2 of an 8-beat burst -> gnt, rom_ce, rd_valid all 0 immediately and no further rd_valid; after release, req[2] addr 0x40 len 0 -> single beat 0xBF, rd_id=2.
- Late req change: change req_addr[0] and deassert req[0] during its burst -> original addresses and full length still issued.
